// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the RX and the future TX.
package uart_pkg;

    localparam int UART_OSR_DEF      = 16;
    localparam int UART_DIV_BITS_DEF = 16;
    localparam int UART_DATA_W_DEF   = 8;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic par_en(input parity_mode_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word stream: valid/ready with parity/frame sideband.
interface uart_rx_os_if #(
    parameter int DATA_WIDTH_MAX = 8
) ();

    logic [DATA_WIDTH_MAX-1:0] m_data;
    logic                      m_valid;
    logic                      m_ready;
    logic                      m_err_parity;
    logic                      m_err_frame;

    modport master (
        output m_data,
        output m_valid,
        output m_err_parity,
        output m_err_frame,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_err_parity,
        input  m_err_frame,
        output m_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; clr holds the phase at zero.
module uart_baud_tick #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [DIV_BITS-1:0] div,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt;

    // >= keeps the divider sane if div shrinks mid-count
    assign tick = !clr && (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with valid/ready output and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH_MAX = UART_DATA_W_DEF,
    parameter int DIV_BITS       = UART_DIV_BITS_DEF,
    parameter int OSR            = UART_OSR_DEF,
    parameter int LEN_W          = $clog2(DATA_WIDTH_MAX) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic                rx_i,
    uart_rx_os_if.master        m,
    output logic                err_overrun,
    output logic                break_det,
    output logic                busy
);

    localparam int OS_W  = $clog2(OSR);
    localparam int IDX_W = $clog2(DATA_WIDTH_MAX);
    localparam logic [OS_W-1:0]  C_HALF = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  C_FULL = OS_W'(OSR - 1);
    localparam logic [LEN_W-1:0] L_MAX  = LEN_W'(DATA_WIDTH_MAX);

    rx_state_t                 state;
    logic                      rx_q1;
    logic                      rx_s;
    logic                      tick;
    logic                      bit_val;
    logic [OS_W-1:0]           os_cnt;
    logic [LEN_W-1:0]          bit_cnt;
    logic [LEN_W-1:0]          len_eff;
    logic [LEN_W-1:0]          len_q;
    parity_mode_t              par_q;
    logic                      stop2_q;
    logic                      stop_idx;
    logic [DATA_WIDTH_MAX-1:0] data_q;
    logic                      pbit_q;
    logic                      perr_q;
    logic                      ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx_i;
            rx_s  <= rx_q1;
        end
    end

    uart_baud_tick #(
        .DIV_BITS (DIV_BITS)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == RX_IDLE),
        .div   (cfg_div),
        .tick  (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] s_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hist <= 2'b11;
        end else if (tick) begin
            s_hist <= {s_hist[0], rx_s};
        end
    end

    // window trails the decision tick so frame timing matches the plain build
    assign bit_val = maj3(s_hist[1], s_hist[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign len_eff = ((cfg_len == '0) || (cfg_len > L_MAX)) ? L_MAX : cfg_len;
    assign busy    = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RX_IDLE;
            os_cnt         <= '0;
            bit_cnt        <= '0;
            len_q          <= '0;
            par_q          <= PAR_NONE;
            stop2_q        <= 1'b0;
            stop_idx       <= 1'b0;
            data_q         <= '0;
            pbit_q         <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            m.m_data       <= '0;
            m.m_valid      <= 1'b0;
            m.m_err_parity <= 1'b0;
            m.m_err_frame  <= 1'b0;
            err_overrun    <= 1'b0;
            break_det      <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            break_det   <= 1'b0;
            if (m.m_valid && m.m_ready) begin
                m.m_valid <= 1'b0;
            end

            unique case (state)
                RX_IDLE: begin
                    os_cnt   <= '0;
                    stop_idx <= 1'b0;
                    if (!rx_s) begin
                        state   <= RX_START;
                        len_q   <= len_eff;
                        par_q   <= parity_mode_t'(cfg_parity);
                        stop2_q <= cfg_stop2;
                        data_q  <= '0;
                        pbit_q  <= 1'b0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end

                RX_START: begin
                    if (tick) begin
                        if (os_cnt == C_HALF) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= bit_val ? RX_IDLE : RX_DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                RX_DATA: begin
                    if (tick) begin
                        if (os_cnt == C_FULL) begin
                            os_cnt <= '0;
                            data_q[bit_cnt[IDX_W-1:0]] <= bit_val;
                            if (bit_cnt == len_q - 1'b1) begin
                                state <= par_en(par_q) ? RX_PARITY : RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                RX_PARITY: begin
                    if (tick) begin
                        if (os_cnt == C_FULL) begin
                            os_cnt <= '0;
                            pbit_q <= bit_val;
                            perr_q <= ((^data_q) ^ bit_val) != (par_q == PAR_ODD);
                            state  <= RX_STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                RX_STOP: begin
                    if (tick) begin
                        if (os_cnt == C_FULL) begin
                            os_cnt <= '0;
                            if (!stop_idx && !bit_val && (data_q == '0) && !pbit_q) begin
                                break_det <= 1'b1;
                                state     <= RX_BREAK;
                            end else if (!stop_idx && stop2_q) begin
                                ferr_q   <= !bit_val;
                                stop_idx <= 1'b1;
                            end else begin
                                state <= RX_IDLE;
                                if (!m.m_valid || m.m_ready) begin
                                    m.m_data       <= data_q;
                                    m.m_err_parity <= perr_q;
                                    m.m_err_frame  <= ferr_q | !bit_val;
                                    m.m_valid      <= 1'b1;
                                end else begin
                                    err_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                RX_BREAK: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule
